mfu_mac: RTL
============

Name: mfu_mac

Overview:
Precision-scalable signed multiply-accumulate unit. It is the parametrised successor to the mode-selectable multiplier inside the CNN accelerator PE array. Each beat it computes a dot product of one, two or four signed sub-word lanes and accumulates results across beats under valid/first/last framing. It presents a saturated accumulator result once per frame.

Parameters:
DATA_W, 8, operand width; power of two, >= 8; lane widths DATA_W, DATA_W/2, DATA_W/4
ACC_W, 32, accumulator and result width; >= 2*DATA_W
SATURATE, 1, 1 = clamp accumulator on overflow; 0 = two's-complement wrap

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
in_valid  input  1  beat qualifier for a, b, mode, first, last
a  input  DATA_W  signed operand / packed signed lanes
b  input  DATA_W  signed operand / packed signed lanes
mode  input  2  00: 1 lane x DATA_W; 01: 2 lanes x DATA_W/2; 10: 4 lanes x DATA_W/4; 11: reserved
first  input  1  beat starts a new accumulation frame
last  input  1  beat ends the frame
p  output  2*DATA_W  signed lane-sum of the most recent valid beat
out_valid  output  1  one-cycle pulse, frame result valid
out_acc  output  ACC_W  signed frame result
sat  output  1  overflow occurred in the current or just-ended frame (sticky)

Behaviour:
- Reset: asynchronous, active-low. All pipeline registers, p, out_valid, out_acc, sat and the accumulator clear to 0 immediately when nrst falls. This also applies mid-frame; no partial result is emitted.
- Lanes: lane 0 occupies the LSBs. Each lane is two's-complement. Lane products are sign-extended, then summed to form p.
  - mode 11: p = 0 and the beat still counts; not an error.
- Stage S1, edge k: when in_valid=1, register a, b, mode, first and last, and set s1_valid. When in_valid=0, s1_valid clears and the other S1 registers hold.
- Stage S2, edge k+1, only when s1_valid=1:
  - p <= lane sum.
  - If s1_first=1: acc <= sext(p) and sat <= 0.
  - Otherwise: acc <= acc + sext(p).
- Overflow with SATURATE=1: clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and set sat. sat stays set until the next first beat.
- Overflow with SATURATE=0: the accumulator wraps and sat still records the overflow.
- Output: out_valid <= s1_valid & s1_last, with out_acc <= the new acc value. out_valid is high for exactly the one cycle after edge k+1. out_acc holds its value until the next frame result.
- Latency: 2 edges from sample to result; full throughput of 1 beat per cycle with no stalls.
- Bubbles (in_valid=0) between beats leave acc, p and sat unchanged.
- first=1 and last=1 on the same beat form a single-beat frame: out_acc = sext(p).
- last=1 without a preceding first continues the existing acc.
- Mode may change beat to beat within a frame.

Test Plan:
1. mode=00, a=-128, b=-128, first=last=1 -> p=16384; two edges later out_valid=1 for one cycle with out_acc=16384; sat=0.
2. mode=01, a=8'h3F (lanes 3, -1), b=8'h2E (lanes 2, -2), first=last=1 -> 3*2 + (-1)(-2) = 8; p=8, out_acc=8.
3. mode=10, a=b=8'h6C (lanes MSB to LSB: 1, -2, -1, 0), first=last=1 -> 1+4+1+0: p=6, out_acc=6. Then the same beat with mode=11 -> p=0, out_acc=0.
4. Four beats mode=00, a=b=127, first on beat 0, last on beat 3, with one in_valid=0 bubble after beat 1 -> single out_valid pulse, out_acc=64516; out_acc not updated on intermediate beats.
5. ACC_W=16, SATURATE=1, three beats of 127*127 -> running acc 16129, 32258, then clamp to 32767; out_acc=32767, sat=1. The next frame's first beat clears sat.
6. Start a frame, drive nrst=0 asynchronously between clock edges after beat 2 -> out_valid, out_acc, p and sat go 0 immediately. After release, a new first=last beat (5*5, mode=00) -> out_acc=25 with no contribution from the aborted frame.

Source files
------------

// File: rtl/mfu_mac_if.sv
// Beat/result bus of the precision-scalable MAC. The source drives the beat
// fields; the MAC drives the lane sum and the per-frame result.
interface mfu_mac_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
);
  logic                  in_valid;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic [1:0]            mode;
  logic                  first;
  logic                  last;
  logic [2*DATA_W-1:0]   p;
  logic                  out_valid;
  logic [ACC_W-1:0]      out_acc;
  logic                  sat;

  modport master (
    output in_valid, a, b, mode, first, last,
    input  p, out_valid, out_acc, sat
  );

  modport slave (
    input  in_valid, a, b, mode, first, last,
    output p, out_valid, out_acc, sat
  );
endinterface

// File: rtl/mfu_mac.sv
// Precision-scalable signed MAC: per beat, a dot product over 1/2/4 signed
// sub-word lanes, accumulated across a first..last frame, with an optional
// saturating accumulator and a sticky overflow flag.
module mfu_mac #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic    clk,
  input  logic    nrst,
  mfu_mac_if.slave bus
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned HW = DATA_W / 2;
  localparam int unsigned QW = DATA_W / 4;
  localparam int unsigned SW = ACC_W + 1;

  logic                     s1_valid;
  logic [DATA_W-1:0]        s1_a;
  logic [DATA_W-1:0]        s1_b;
  logic [1:0]               s1_mode;
  logic                     s1_first;
  logic                     s1_last;

  logic signed [PW-1:0]     lane_sum;
  logic signed [PW-1:0]     la;
  logic signed [PW-1:0]     lb;
  logic signed [ACC_W-1:0]  p_ext;
  logic signed [SW-1:0]     sum_wide;
  logic                     ovf;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     sat_next;

  logic [PW-1:0]            p_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     sat_q;
  logic                     out_valid_q;
  logic [ACC_W-1:0]         out_acc_q;

  // S1: capture the beat; sideband holds across bubbles
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a     <= bus.a;
        s1_b     <= bus.b;
        s1_mode  <= bus.mode;
        s1_first <= bus.first;
        s1_last  <= bus.last;
      end
    end
  end

  // Lane products, sign-extended to the full product width and summed
  always_comb begin
    lane_sum = '0;
    la       = '0;
    lb       = '0;
    case (s1_mode)
      2'b00: begin
        la       = PW'($signed(s1_a));
        lb       = PW'($signed(s1_b));
        lane_sum = la * lb;
      end
      2'b01: begin
        for (int i = 0; i < 2; i++) begin
          la       = PW'($signed(s1_a[i*HW +: HW]));
          lb       = PW'($signed(s1_b[i*HW +: HW]));
          lane_sum = lane_sum + la * lb;
        end
      end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          la       = PW'($signed(s1_a[i*QW +: QW]));
          lb       = PW'($signed(s1_b[i*QW +: QW]));
          lane_sum = lane_sum + la * lb;
        end
      end
      default: lane_sum = '0;
    endcase
  end

  // Accumulate with one guard bit; overflow when the guard and sign disagree
  always_comb begin
    p_ext    = ACC_W'(lane_sum);
    sum_wide = SW'(acc_q) + SW'(p_ext);
    ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_next = sum_wide[ACC_W-1:0];
    sat_next = sat_q | ovf;
    if (ovf && SATURATE) begin
      acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
    if (s1_first) begin
      acc_next = p_ext;
      sat_next = 1'b0;
    end
  end

  // S2: update lane sum, accumulator, sticky flag and the frame result
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p_q         <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
    end else begin
      out_valid_q <= s1_valid & s1_last;
      if (s1_valid) begin
        p_q   <= lane_sum;
        acc_q <= acc_next;
        sat_q <= sat_next;
        if (s1_last) begin
          out_acc_q <= acc_next;
        end
      end
    end
  end

  assign bus.p         = p_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.sat       = sat_q;

endmodule
